pattern_hflipper: RTL and testbench

Pixel-line horizontal flipper for the GPU background and sprite pipelines. It takes one 8-pixel pattern line of 2-bit pixels, as read from pattern memory, and reverses the pixel order when horizontal flip is requested. It provides a zero-latency combinational result for the scanline-fill path. It also provides a one-deep registered valid/ready stage for pipelined consumers.

---
 rtl/pattern_hflipper_if.sv | 41 ++++
 rtl/pattern_hflipper.sv | 67 ++++++
 tb/tb_pattern_hflipper.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_hflipper_if.sv
// rtl/pattern_hflipper_if.sv - line/handshake bundle for the pattern horizontal flipper
interface pattern_hflipper_if #(
  parameter int PIXEL_BITS = 2,
  parameter int PIXELS     = 8
);
  localparam int LINE_W = PIXEL_BITS * PIXELS;

  logic [LINE_W-1:0] pattern_i;
  logic              hflip_i;
  logic [LINE_W-1:0] line_o;
  logic              in_valid_i;
  logic              in_ready_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [LINE_W-1:0] line_q_o;
  logic              hflip_q_o;

  modport slave (
    input  pattern_i,
    input  hflip_i,
    input  in_valid_i,
    input  out_ready_i,
    output line_o,
    output in_ready_o,
    output out_valid_o,
    output line_q_o,
    output hflip_q_o
  );

  modport master (
    output pattern_i,
    output hflip_i,
    output in_valid_i,
    output out_ready_i,
    input  line_o,
    input  in_ready_o,
    input  out_valid_o,
    input  line_q_o,
    input  hflip_q_o
  );
endinterface

// File: rtl/pattern_hflipper.sv
// rtl/pattern_hflipper.sv - combinational pattern-line mirror plus one-entry valid/ready stage
module pattern_hflipper #(
  parameter int PIXEL_BITS = 2,
  parameter int PIXELS     = 8
) (
  input  logic                clk,
  input  logic                rst,
  pattern_hflipper_if.slave   bus
);
  localparam int LINE_W = PIXEL_BITS * PIXELS;

  // Pixel 0 sits in the top bits; mirroring swaps whole pixels, keeping bit order inside each.
  function automatic logic [LINE_W-1:0] flip_line(input logic [LINE_W-1:0] p, input logic h);
    logic [LINE_W-1:0] r;
    r = p;
    if (h) begin
      for (int x = 0; x < PIXELS; x++) begin
        r[PIXEL_BITS*x +: PIXEL_BITS] = p[PIXEL_BITS*(PIXELS-1-x) +: PIXEL_BITS];
      end
    end
    return r;
  endfunction

  logic [LINE_W-1:0] flipped;
  logic              in_ready;
  logic              accept;

  logic              out_valid_d, out_valid_q;
  logic [LINE_W-1:0] line_d,      line_q;
  logic              hflip_d,     hflip_q;

  assign flipped = flip_line(bus.pattern_i, bus.hflip_i);

  always_comb begin
    in_ready    = !out_valid_q || bus.out_ready_i;
    accept      = bus.in_valid_i && in_ready;
    out_valid_d = out_valid_q;
    line_d      = line_q;
    hflip_d     = hflip_q;
    if (accept) begin
      // A same-cycle drain and accept simply overwrites the old entry.
      out_valid_d = 1'b1;
      line_d      = flipped;
      hflip_d     = bus.hflip_i;
    end else if (out_valid_q && bus.out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      line_q      <= '0;
      hflip_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      line_q      <= line_d;
      hflip_q     <= hflip_d;
    end
  end

  assign bus.line_o      = flipped;
  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.line_q_o    = line_q;
  assign bus.hflip_q_o   = hflip_q;
endmodule

// File: tb/tb_pattern_hflipper.sv
// tb/tb_pattern_hflipper.sv - self-checking bench for pattern_hflipper
module tb_pattern_hflipper;
  localparam int PB = 2;
  localparam int NP = 8;
  localparam int LW = PB * NP;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pattern_hflipper_if #(.PIXEL_BITS(PB), .PIXELS(NP)) bus ();

  pattern_hflipper #(.PIXEL_BITS(PB), .PIXELS(NP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: unpack into a pixel array (index = screen x), optionally reverse, repack.
  function automatic logic [LW-1:0] ref_flip(input logic [LW-1:0] p, input logic h);
    logic [PB-1:0] pix [NP];
    logic [PB-1:0] outpix [NP];
    logic [LW-1:0] r;
    for (int x = 0; x < NP; x++) pix[x] = p[LW-1-PB*x -: PB];
    for (int x = 0; x < NP; x++) outpix[x] = h ? pix[NP-1-x] : pix[x];
    r = '0;
    for (int x = 0; x < NP; x++) r = (r << PB) | LW'(outpix[x]);
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks += 4;
    if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid_o); end
    if (bus.line_q_o !== 16'h0000) begin failures++; $display("FAIL reset_line_q got=%h exp=0000", bus.line_q_o); end
    if (bus.hflip_q_o !== 1'b0) begin failures++; $display("FAIL reset_hflip_q got=%b exp=0", bus.hflip_q_o); end
    if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready_o); end
    tick;
    #2 rst = 1'b0;
    tick;
  endtask

  task automatic test_comb_vectors;
    logic [LW-1:0] pat [5];
    logic          hf  [5];
    logic [LW-1:0] exp [5];
    logic [LW-1:0] p;
    logic          h;
    pat[0] = 16'h1231; hf[0] = 1'b1; exp[0] = 16'h4C84;
    pat[1] = 16'h1231; hf[1] = 1'b0; exp[1] = 16'h1231;
    pat[2] = 16'h1BE4; hf[2] = 1'b1; exp[2] = 16'h1BE4;
    pat[3] = 16'hCCCC; hf[3] = 1'b1; exp[3] = 16'h3333;
    pat[4] = 16'h3333; hf[4] = 1'b1; exp[4] = 16'hCCCC;
    for (int i = 0; i < 5; i++) begin
      bus.pattern_i = pat[i];
      bus.hflip_i   = hf[i];
      #1;
      checks++;
      if (bus.line_o !== exp[i]) begin
        failures++;
        $display("FAIL comb_vector%0d got=%h exp=%h", i, bus.line_o, exp[i]);
      end
    end
    for (int i = 0; i < 300; i++) begin
      p = LW'($urandom);
      h = 1'($urandom);
      bus.pattern_i = p;
      bus.hflip_i   = h;
      #1;
      checks++;
      if (bus.line_o !== ref_flip(p, h)) begin
        failures++;
        $display("FAIL comb_random p=%h h=%b got=%h exp=%h", p, h, bus.line_o, ref_flip(p, h));
      end
    end
  endtask

  task automatic test_involution;
    logic [LW-1:0] once;
    int            bad;
    bad = 0;
    for (int v = 0; v < 65536; v++) begin
      bus.pattern_i = LW'(v);
      bus.hflip_i   = 1'b0;
      #1;
      if (bus.line_o !== LW'(v)) begin
        bad++;
        if (bad < 5) $display("FAIL involution_noflip p=%h got=%h exp=%h", LW'(v), bus.line_o, LW'(v));
      end
      bus.hflip_i = 1'b1;
      #1;
      once = bus.line_o;
      bus.pattern_i = once;
      #1;
      if (bus.line_o !== LW'(v)) begin
        bad++;
        if (bad < 5) $display("FAIL involution_twice p=%h got=%h exp=%h", LW'(v), bus.line_o, LW'(v));
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL involution_total got=%0d bad exp=0", bad);
    end
  endtask

  task automatic test_streaming;
    logic [LW-1:0] pat [3];
    logic          hf  [3];
    logic [LW-1:0] exp [3];
    pat[0] = 16'h1231; hf[0] = 1'b1; exp[0] = 16'h4C84;
    pat[1] = 16'hCCCC; hf[1] = 1'b1; exp[1] = 16'h3333;
    pat[2] = 16'h1BE4; hf[2] = 1'b0; exp[2] = 16'h1BE4;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid_i = 1'b1;
      bus.pattern_i  = pat[i];
      bus.hflip_i    = hf[i];
      #1;
      checks++;
      if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL stream_in_ready%0d got=%b exp=1", i, bus.in_ready_o); end
      tick;
      checks += 3;
      if (bus.out_valid_o !== 1'b1) begin failures++; $display("FAIL stream_out_valid%0d got=%b exp=1", i, bus.out_valid_o); end
      if (bus.line_q_o !== exp[i]) begin failures++; $display("FAIL stream_line_q%0d got=%h exp=%h", i, bus.line_q_o, exp[i]); end
      if (bus.hflip_q_o !== hf[i]) begin failures++; $display("FAIL stream_hflip_q%0d got=%b exp=%b", i, bus.hflip_q_o, hf[i]); end
    end
    bus.in_valid_i = 1'b0;
    tick;
    checks++;
    if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL stream_drain got=%b exp=0", bus.out_valid_o); end
  endtask

  task automatic test_backpressure;
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.pattern_i   = 16'h1231;
    bus.hflip_i     = 1'b1;
    tick;
    bus.out_ready_i = 1'b0;
    bus.pattern_i   = 16'hCCCC;
    bus.hflip_i     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks += 3;
      if (bus.in_ready_o !== 1'b0) begin failures++; $display("FAIL bp_in_ready%0d got=%b exp=0", i, bus.in_ready_o); end
      if (bus.line_q_o !== 16'h4C84) begin failures++; $display("FAIL bp_line_hold%0d got=%h exp=4c84", i, bus.line_q_o); end
      if (bus.out_valid_o !== 1'b1) begin failures++; $display("FAIL bp_valid_hold%0d got=%b exp=1", i, bus.out_valid_o); end
      tick;
    end
    bus.out_ready_i = 1'b1;
    #1;
    checks++;
    if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready_o); end
    tick;
    bus.in_valid_i = 1'b0;
    checks += 2;
    if (bus.line_q_o !== 16'h3333) begin failures++; $display("FAIL bp_release_line got=%h exp=3333", bus.line_q_o); end
    if (bus.out_valid_o !== 1'b1) begin failures++; $display("FAIL bp_release_valid got=%b exp=1", bus.out_valid_o); end
    tick;
  endtask

  task automatic test_random_stream;
    logic [LW:0] q [$];
    logic [LW:0] head;
    logic        exp_ready;
    for (int cyc = 0; cyc < 500; cyc++) begin
      bus.in_valid_i  = ($urandom_range(0, 3) != 0);
      bus.out_ready_i = ($urandom_range(0, 2) != 0);
      bus.pattern_i   = LW'($urandom);
      bus.hflip_i     = 1'($urandom);
      #1;
      exp_ready = (q.size() == 0) || bus.out_ready_i;
      checks += 2;
      if (bus.out_valid_o !== (q.size() != 0)) begin
        failures++;
        $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid_o, q.size() != 0);
      end
      if (bus.in_ready_o !== exp_ready) begin
        failures++;
        $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready_o, exp_ready);
      end
      if (q.size() != 0 && bus.out_ready_i) begin
        head = q.pop_front();
        checks++;
        if ({bus.hflip_q_o, bus.line_q_o} !== head) begin
          failures++;
          $display("FAIL rand_data cyc=%0d got=%b/%h exp=%b/%h", cyc, bus.hflip_q_o, bus.line_q_o, head[LW], head[LW-1:0]);
        end
      end
      if (bus.in_valid_i && exp_ready) q.push_back({bus.hflip_i, ref_flip(bus.pattern_i, bus.hflip_i)});
      tick;
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    tick;
  endtask

  task automatic test_async_reset;
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    bus.pattern_i   = 16'h1BE4;
    bus.hflip_i     = 1'b1;
    tick;
    bus.in_valid_i = 1'b0;
    checks++;
    if (bus.out_valid_o !== 1'b1) begin failures++; $display("FAIL arst_setup_valid got=%b exp=1", bus.out_valid_o); end
    #2 rst = 1'b1;
    #1;
    checks += 4;
    if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", bus.out_valid_o); end
    if (bus.line_q_o !== 16'h0000) begin failures++; $display("FAIL arst_line_q got=%h exp=0000", bus.line_q_o); end
    if (bus.hflip_q_o !== 1'b0) begin failures++; $display("FAIL arst_hflip_q got=%b exp=0", bus.hflip_q_o); end
    if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL arst_in_ready got=%b exp=1", bus.in_ready_o); end
    bus.pattern_i = 16'h1231;
    #1;
    checks++;
    if (bus.line_o !== 16'h4C84) begin failures++; $display("FAIL arst_comb_track got=%h exp=4c84", bus.line_o); end
    bus.in_valid_i = 1'b1;
    tick;
    checks++;
    if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL arst_held_valid got=%b exp=0", bus.out_valid_o); end
    #1 rst = 1'b0;
    bus.pattern_i = 16'h3333;
    bus.hflip_i   = 1'b1;
    tick;
    bus.in_valid_i = 1'b0;
    checks += 3;
    if (bus.out_valid_o !== 1'b1) begin failures++; $display("FAIL arst_release_valid got=%b exp=1", bus.out_valid_o); end
    if (bus.line_q_o !== 16'hCCCC) begin failures++; $display("FAIL arst_release_line got=%h exp=cccc", bus.line_q_o); end
    if (bus.hflip_q_o !== 1'b1) begin failures++; $display("FAIL arst_release_hflip got=%b exp=1", bus.hflip_q_o); end
    bus.out_ready_i = 1'b1;
    tick;
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst             = 1'b1;
    bus.pattern_i   = '0;
    bus.hflip_i     = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    test_reset;
    test_comb_vectors;
    test_involution;
    tick;
    test_streaming;
    test_backpressure;
    test_random_stream;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
